lc3_mem_responder: RTL

- Memory-side responder for the LC-3 CPU's memory requests.
- Accepts read and write requests issued from MAR/MDR and performs a timed SRAM access.
- Returns read data to the CPU's MDR input with a one-cycle ready pulse.
- Decodes the memory-mapped I/O address 0xFFFF to board switches (read) and a hex-display register (write).

---
 rtl/lc3_mem_responder_pkg.sv | 13 +
 rtl/lc3_mem_responder_if.sv | 23 ++
 rtl/lc3_mem_responder_sync2.sv | 27 ++
 rtl/lc3_mem_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

  localparam int          DATA_W  = 16;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// CPU-side request/response bus between the LC-3 core (master) and the
// memory responder (slave).
interface lc3_mem_if;
  import lc3_mem_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy
  );
endinterface

// File: rtl/lc3_mem_responder_sync2.sv
// Two-flop synchronizer with synchronous active-low clear.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: turns CPU MAR/MDR requests into timed SRAM
// accesses and returns read data with a one-cycle ready pulse.
// Optional macro LC3_MEM_IO_MAP_EN maps address 0xFFFF to board switches
// (read) and the hex-display register (write); without it every address,
// including 0xFFFF, goes to SRAM and hex_out is tied low.
//
// state  | meaning
// IDLE   | waiting for req; an accepted request launches the access
// ACCESS | SRAM strobes active, down-counter running to zero
// DONE   | strobes released, ready pulse is raised on leaving
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               reset,
  lc3_mem_if.slave           cpu,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  input  logic [DATA_W-1:0]  sw,
  output logic [DATA_W-1:0]  hex_out
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_t         state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               ready_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [DATA_W-1:0]  sram_wdata_q;
  logic               ce_n_q;
  logic               oe_n_q;
  logic               we_n_q;
  logic               is_io;

`ifdef LC3_MEM_IO_MAP_EN
  logic [DATA_W-1:0]  sw_sync;
  logic [DATA_W-1:0]  hex_q;

  sync2 #(.WIDTH(DATA_W)) u_sw_sync (
    .clk     (clk),
    .rst_n_i (reset),
    .d_i     (sw),
    .q_o     (sw_sync)
  );

  assign is_io   = (cpu.addr == IO_ADDR);
  assign hex_out = hex_q;
`else
  logic unused_sw;

  assign unused_sw = ^sw;
  assign is_io     = 1'b0;
  assign hex_out   = '0;
`endif

  // Access sequencer: state, strobes, wait counter and returned data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
`ifdef LC3_MEM_IO_MAP_EN
      hex_q        <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu.req) begin
            we_q <= cpu.we;
            if (is_io) begin
`ifdef LC3_MEM_IO_MAP_EN
              if (cpu.we) hex_q   <= cpu.wdata;
              else        rdata_q <= sw_sync;
`endif
              state_q <= DONE;
            end else begin
              cnt_q        <= WS;
              sram_addr_q  <= SRAM_AW'(cpu.addr);
              sram_wdata_q <= cpu.wdata;
              ce_n_q       <= 1'b0;
              oe_n_q       <= cpu.we;
              we_n_q       <= ~cpu.we;
              state_q      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) rdata_q <= sram_rdata;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            // Release WE one cycle early so address/data are held past it.
            if (cnt_q == 4'd1) we_n_q <= 1'b1;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu.rdata  = rdata_q;
  assign cpu.ready  = ready_q;
  assign cpu.busy   = (state_q != IDLE);
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule
